// File: rtl/mips_pkg.sv
// Shared EX-stage definitions: ALU op codes, forward selects,
// multiplier FSM encoding and pipeline register bundles.
package mips_pkg;

  localparam int XLEN = 32;

  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_OR    = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_XOR   = 4'b0011;
  localparam logic [3:0] ALU_NOR   = 4'b0100;
  localparam logic [3:0] ALU_SLTU  = 4'b0101;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_SLT   = 4'b0111;
  localparam logic [3:0] ALU_MULTU = 4'b1000;
  localparam logic [3:0] ALU_MULT  = 4'b1001;
  localparam logic [3:0] ALU_MFHI  = 4'b1010;
  localparam logic [3:0] ALU_MFLO  = 4'b1011;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam logic [1:0] MUL_IDLE = 2'd0;
  localparam logic [1:0] MUL_BUSY = 2'd1;
  localparam logic [1:0] MUL_DONE = 2'd2;

  typedef struct packed {
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [4:0]      rs;
    logic [4:0]      rt;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm;
    logic [3:0]      alu_ctl;
    logic            alu_src;
    logic            reg_dst;
    logic            reg_write;
    logic            mem_write;
    logic            mem_to_reg;
  } id_ex_t;

  typedef struct packed {
    logic [XLEN-1:0] alu_out;
    logic [XLEN-1:0] write_data;
    logic [4:0]      write_reg;
    logic            reg_write;
    logic            mem_write;
    logic            mem_to_reg;
  } ex_mem_t;

  function automatic logic is_mul(input logic [3:0] op);
    return (op == ALU_MULT) || (op == ALU_MULTU);
  endfunction

endpackage

// File: rtl/execute_stage_mul.sv
// Iterative 32-step shift-add multiplier with HI/LO.
// Signed ops multiply magnitudes and negate the 64-bit product.
module mul_unit
  import mips_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int MUL_STEPS = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  logic [1:0]         state;
  logic [4:0]         cnt;
  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_nxt;
  logic [2*WIDTH-1:0] res;
  logic [WIDTH-1:0]   mplier;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic               neg;

  assign a_mag = (is_signed && a[WIDTH-1]) ? -a : a;
  assign b_mag = (is_signed && b[WIDTH-1]) ? -b : b;

  assign acc_nxt = acc + (mplier[0] ? mcand : '0);
  assign res     = neg ? -acc_nxt : acc_nxt;

  // Releases EX in the DONE cycle so the op leaves on that edge.
  assign busy = start && (state != MUL_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= MUL_IDLE;
      cnt    <= '0;
      mcand  <= '0;
      acc    <= '0;
      mplier <= '0;
      neg    <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      case (state)
        MUL_IDLE: begin
          if (start) begin
            mcand  <= {{WIDTH{1'b0}}, a_mag};
            mplier <= b_mag;
            acc    <= '0;
            neg    <= is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
            cnt    <= '0;
            state  <= MUL_BUSY;
          end
        end
        MUL_BUSY: begin
          acc    <= acc_nxt;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 5'd1;
          if (cnt == 5'(MUL_STEPS - 1)) begin
            {hi, lo} <= res;
            state    <= MUL_DONE;
          end
        end
        MUL_DONE: state <= MUL_IDLE;
        default:  state <= MUL_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/execute_stage.sv
// MIPS EX stage: ID/EX register, forward muxes, ALU,
// iterative multiplier and EX/MEM register.
module execute_stage
  import mips_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int MUL_STEPS = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             FlushE,
  input  logic [WIDTH-1:0] RD1D,
  input  logic [WIDTH-1:0] RD2D,
  input  logic [4:0]       RsD,
  input  logic [4:0]       RtD,
  input  logic [4:0]       RdD,
  input  logic [WIDTH-1:0] SignImmD,
  input  logic [3:0]       ALUControlD,
  input  logic             ALUSrcD,
  input  logic             RegDstD,
  input  logic             RegWriteD,
  input  logic             MemWriteD,
  input  logic             MemtoRegD,
  input  logic [1:0]       ForwardAE,
  input  logic [1:0]       ForwardBE,
  input  logic [WIDTH-1:0] ResultW,
  output logic [4:0]       RsE,
  output logic [4:0]       RtE,
  output logic [4:0]       WriteRegE,
  output logic             RegWriteE,
  output logic             MemtoRegE,
  output logic             MulBusyE,
  output logic [WIDTH-1:0] ALUOutM,
  output logic [WIDTH-1:0] WriteDataM,
  output logic [4:0]       WriteRegM,
  output logic             RegWriteM,
  output logic             MemWriteM,
  output logic             MemtoRegM
);

  id_ex_t  ex;
  id_ex_t  ex_d;
  ex_mem_t mem;
  ex_mem_t mem_d;

  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] alu_y;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  always_comb begin
    ex_d            = '0;
    ex_d.rd1        = RD1D;
    ex_d.rd2        = RD2D;
    ex_d.rs         = RsD;
    ex_d.rt         = RtD;
    ex_d.rd         = RdD;
    ex_d.imm        = SignImmD;
    ex_d.alu_ctl    = ALUControlD;
    ex_d.alu_src    = ALUSrcD;
    ex_d.reg_dst    = RegDstD;
    ex_d.reg_write  = RegWriteD;
    ex_d.mem_write  = MemWriteD;
    ex_d.mem_to_reg = MemtoRegD;
  end

  // A running multiply is never killed by a flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex <= '0;
    end else if (!MulBusyE) begin
      if (FlushE) ex <= '0;
      else        ex <= ex_d;
    end
  end

  always_comb begin
    src_a = ex.rd1;
    unique case (1'b1)
      (ForwardAE == FWD_WB):  src_a = ResultW;
      (ForwardAE == FWD_MEM): src_a = ALUOutM;
      default:                src_a = ex.rd1;
    endcase
  end

  always_comb begin
    wdata = ex.rd2;
    unique case (1'b1)
      (ForwardBE == FWD_WB):  wdata = ResultW;
      (ForwardBE == FWD_MEM): wdata = ALUOutM;
      default:                wdata = ex.rd2;
    endcase
  end

  assign src_b = ex.alu_src ? ex.imm : wdata;

  always_comb begin
    alu_y = '0;
    case (ex.alu_ctl)
      ALU_AND:  alu_y = src_a & src_b;
      ALU_OR:   alu_y = src_a | src_b;
      ALU_ADD:  alu_y = src_a + src_b;
      ALU_XOR:  alu_y = src_a ^ src_b;
      ALU_NOR:  alu_y = ~(src_a | src_b);
      ALU_SLTU: alu_y = {{(WIDTH-1){1'b0}}, src_a < src_b};
      ALU_SUB:  alu_y = src_a - src_b;
      ALU_SLT:  alu_y = {{(WIDTH-1){1'b0}},
                         $signed(src_a) < $signed(src_b)};
      ALU_MFHI: alu_y = hi;
      ALU_MFLO: alu_y = lo;
      default:  alu_y = '0;
    endcase
  end

  mul_unit #(
    .WIDTH     (WIDTH),
    .MUL_STEPS (MUL_STEPS)
  ) u_mul (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (is_mul(ex.alu_ctl)),
    .is_signed (ex.alu_ctl == ALU_MULT),
    .a         (src_a),
    .b         (wdata),
    .busy      (MulBusyE),
    .hi        (hi),
    .lo        (lo)
  );

  assign RsE       = ex.rs;
  assign RtE       = ex.rt;
  assign WriteRegE = ex.reg_dst ? ex.rd : ex.rt;
  assign RegWriteE = ex.reg_write;
  assign MemtoRegE = ex.mem_to_reg;

  always_comb begin
    mem_d            = '0;
    mem_d.alu_out    = alu_y;
    mem_d.write_data = wdata;
    mem_d.write_reg  = WriteRegE;
    mem_d.reg_write  = ex.reg_write;
    mem_d.mem_write  = ex.mem_write;
    mem_d.mem_to_reg = ex.mem_to_reg;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        mem <= '0;
    else if (MulBusyE) mem <= '0;
    else               mem <= mem_d;
  end

  assign ALUOutM    = mem.alu_out;
  assign WriteDataM = mem.write_data;
  assign WriteRegM  = mem.write_reg;
  assign RegWriteM  = mem.reg_write;
  assign MemWriteM  = mem.mem_write;
  assign MemtoRegM  = mem.mem_to_reg;

endmodule
